icache_fetch_responder: RTL and testbench
=========================================

Name: icache_fetch_responder

Overview:
- Direct-mapped instruction cache that answers the fetch stage's PC each cycle with an instruction word or a stall.
- Sits between the IF stage and the instruction memory.
- Drives the iCacheStall the IF stage uses to freeze its PC; the top-level NOP mux uses it to inject NOPs.
- On a miss, runs a line-fill handshake with backing memory and serves the word once the line is resident.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two; line = WORDS_PER_LINE*32 bits.
- NOP_INSTR, 32'h00000013, word driven on instr while stalling.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pc  input  32  fetch address from IF; word-aligned; bits [1:0] ignored.
- invalidate  input  1  one-cycle pulse; clears every valid bit.
- instr  output  32  fetched instruction; NOP_INSTR when iCacheStall=1.
- iCacheStall  output  1  1 = word not available this cycle, IF must hold PC.
- mem_req  output  1  line-fill request, held high until response.
- mem_addr  output  32  line-aligned fill address (offset bits zero).
- mem_rsp_valid  input  1  memory returns a full line this cycle.
- mem_rsp_data  input  WORDS_PER_LINE*32  line data; word 0 in bits [31:0].
- miss_count  output  32  saturating count of misses detected.

Behaviour:
- Address split:
  - offset = pc[log2(WORDS_PER_LINE)+1 : 2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage: per line a valid bit, tag, and data. Only valid bits and FSM/counter need reset; data/tag are don't-care while invalid.
- Reset values:
  - state=IDLE, all valid=0, mem_req=0, mem_addr=0, miss_count=0.
  - Outputs during reset: instr=NOP_INSTR, iCacheStall=1.
- FSM states: IDLE, FILL.
- IDLE, hit (valid[index] and tag match):
  - Combinational, same-cycle: iCacheStall=0, instr=data[index][offset].
- IDLE, miss:
  - iCacheStall=1 and instr=NOP_INSTR combinationally in the same cycle.
  - At the clock edge: latch mem_addr = {pc[31:offset_msb+1], zeros}, increment miss_count (saturate at 32'hFFFFFFFF), go to FILL.
- FILL:
  - mem_req=1 and iCacheStall=1, regardless of pc.
  - On an edge with mem_rsp_valid=1: write mem_rsp_data into the line selected by the latched mem_addr, set its valid and tag, drop mem_req, return to IDLE.
  - The next cycle re-evaluates the current pc.
- Latency: miss with memory answering in the first FILL cycle gives 2 stall cycles; each extra memory wait cycle adds one stall cycle.
- mem_rsp_valid in IDLE is ignored; no state change.
- mem_addr is stable for the whole FILL period.
- PC redirect during FILL (branch/JALR changes pc):
  - The fill completes for the latched line; it is not cancelled.
  - After returning to IDLE, the new pc is looked up normally and may miss again.
- invalidate:
  - In IDLE: all valid bits clear at the edge; the next cycle misses.
  - In FILL: all valid bits clear at that edge; the in-flight fill still completes and its line becomes valid.
  - Same edge as fill completion: the filled line ends valid, all others invalid.
- Reset mid-FILL: immediate return to IDLE with mem_req=0 and all lines invalid. A later mem_rsp_valid is ignored.
- Conflict miss: a fill to an occupied index overwrites that line's tag and data.

Test Plan:
1. Cold start: deassert reset, pc=0x00000000 → iCacheStall=1 and mem_req=1 with mem_addr=0x00000000 next cycle. Respond with words {0x11,0x22,0x33,0x44} → next cycle instr=0x00000011, iCacheStall=0, miss_count=1.
2. Same-line hits: after test 1, pc 0x4, 0x8, 0xC on consecutive cycles → instr 0x22, 0x33, 0x44 with iCacheStall=0 every cycle; mem_req stays 0.
3. Slow memory: pc=0x00000040 miss, memory waits 3 cycles before mem_rsp_valid → iCacheStall high for exactly 5 cycles, instr=0x00000013 throughout, mem_addr=0x00000040 held.
4. Conflict: 4 lines × 16 B; pc=0x00000000 then pc=0x00000040 (same index 0) → second access misses and refills. Returning to pc=0x0 misses again; miss_count increments each time.
5. Redirect and invalidate during fill:
   - Miss on 0x100; change pc to 0x200 mid-FILL → line 0x100 filled, then miss on 0x200 issued with mem_addr=0x200.
   - invalidate pulse in IDLE → next access to a previously hit pc stalls.
6. Reset mid-FILL: assert reset while mem_req=1 → mem_req=0, iCacheStall=1, instr=NOP immediately. A mem_rsp_valid after release is ignored, and pc=0 still misses.

Source files
------------

// File: rtl/icache_fetch_responder.sv
// Direct-mapped icache answering the IF-stage PC: same-cycle word on a hit, NOP plus stall on a miss.
// Miss costs two stall cycles plus one per memory wait cycle; the line fill is held until mem_rsp_valid.
module icache_fetch_responder #(
  parameter int          NUM_LINES      = 4,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   pc,
  input  logic                          invalidate,
  output logic [31:0]                   instr,
  output logic                          iCacheStall,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  input  logic                          mem_rsp_valid,
  input  logic [WORDS_PER_LINE*32-1:0]  mem_rsp_data,
  output logic [31:0]                   miss_count
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int OFF_IW  = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_W   = 30 - OFF_W - IDX_W;
  localparam int IDX_LSB = 2 + OFF_W;
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [31:0]           data_q [NUM_LINES][WORDS_PER_LINE];

  logic [IDX_W-1:0]      pc_idx, fill_idx;
  logic [TAG_W-1:0]      pc_tag, fill_tag;
  logic [OFF_IW-1:0]     pc_off;
  logic                  hit;
  logic                  fill_done;

  assign pc_idx    = pc[IDX_LSB +: IDX_W];
  assign pc_tag    = pc[31 -: TAG_W];
  assign pc_off    = OFF_IW'((pc >> 2) & 32'(WORDS_PER_LINE - 1));
  // The fill target comes from the latched address, so a PC redirect mid-fill cannot retarget it.
  assign fill_idx  = mem_addr_q[IDX_LSB +: IDX_W];
  assign fill_tag  = mem_addr_q[31 -: TAG_W];
  assign fill_done = (state_q == FILL) && mem_rsp_valid;
  assign hit       = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign mem_req    = (state_q == FILL);
  assign mem_addr   = mem_addr_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    iCacheStall = reset || !hit;
    instr       = NOP_INSTR;
    if (!iCacheStall) begin
      instr = data_q[pc_idx][pc_off];
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mem_addr_d = mem_addr_q;
    miss_cnt_d = miss_cnt_q;
    if (invalidate) begin
      valid_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = FILL;
          mem_addr_d = pc & LINE_MASK;
          if (miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end
      FILL: begin
        // Set after the invalidate clear so a coincident pulse still leaves the new line valid.
        if (mem_rsp_valid) begin
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_addr_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_addr_q <= mem_addr_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_done) begin
      tag_q[fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        data_q[fill_idx][w] <= mem_rsp_data[w*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed plus randomized bench for icache_fetch_responder against a line-address cache model.
module tb_icache_fetch_responder;

  localparam int          NL  = 4;
  localparam int          WPL = 4;
  localparam int          LB  = WPL * 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [31:0]          pc = '0;
  logic                 invalidate = 1'b0;
  logic                 mem_rsp_valid = 1'b0;
  logic [WPL*32-1:0]    mem_rsp_data = '0;
  logic [31:0]          instr;
  logic                 iCacheStall;
  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic [31:0]          miss_count;

  icache_fetch_responder #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .pc(pc), .invalidate(invalidate),
    .instr(instr), .iCacheStall(iCacheStall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: each slot remembers which line address it holds and that line's words.
  bit          m_pend;
  logic [31:0] m_addr;
  logic [31:0] m_cnt;
  bit          m_vld  [NL];
  logic [31:0] m_line [NL];
  logic [31:0] m_data [NL][WPL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LB - 1);
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return int'((a / LB) % NL);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a % LB) / 4);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return !m_pend && m_vld[slot_of(a)] && (m_line[slot_of(a)] == line_of(a));
  endfunction

  function automatic logic [WPL*32-1:0] rnd_line();
    logic [WPL*32-1:0] l;
    for (int w = 0; w < WPL; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    m_pend = 0;
    m_addr = '0;
    m_cnt  = '0;
    for (int i = 0; i < NL; i++) m_vld[i] = 0;
  endtask

  // Drive one cycle's inputs and check every output against the model before the edge.
  task automatic apply(input logic [31:0] p, input logic inv, input logic rv,
                       input logic [WPL*32-1:0] d);
    bit h;
    pc = p; invalidate = inv; mem_rsp_valid = rv; mem_rsp_data = d;
    #2;
    h = m_hit(p);
    chk("stall", 32'(iCacheStall), 32'(!h));
    chk("instr", instr, h ? m_data[slot_of(p)][word_of(p)] : NOP);
    chk("mem_req", 32'(mem_req), 32'(m_pend));
    if (m_pend) chk("mem_addr", mem_addr, m_addr);
    chk("miss_count", miss_count, m_cnt);
  endtask

  task automatic tick();
    bit h;
    int s;
    @(posedge clock);
    h = m_hit(pc);
    if (!m_pend) begin
      if (invalidate) for (int i = 0; i < NL; i++) m_vld[i] = 0;
      if (!h) begin
        m_pend = 1;
        m_addr = line_of(pc);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end else begin
      if (invalidate) for (int i = 0; i < NL; i++) m_vld[i] = 0;
      if (mem_rsp_valid) begin
        s = slot_of(m_addr);
        m_vld[s]  = 1;
        m_line[s] = m_addr;
        for (int w = 0; w < WPL; w++) m_data[s][w] = mem_rsp_data[w*32 +: 32];
        m_pend = 0;
      end
    end
    #1;
  endtask

  task automatic miss_fill(input logic [31:0] p, input int waits);
    apply(p, 0, 0, rnd_line()); tick();
    for (int k = 0; k < waits; k++) begin apply(p, 0, 0, rnd_line()); tick(); end
    apply(p, 0, 1, rnd_line()); tick();
  endtask

  initial begin
    logic [WPL*32-1:0] line0;
    int stalls;
    bit hold;
    logic [31:0] rp;

    model_reset();
    line0 = {32'h44, 32'h33, 32'h22, 32'h11};

    // Reset state
    #2;
    chk("rst_stall", 32'(iCacheStall), 32'd1);
    chk("rst_instr", instr, NOP);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_cnt", miss_count, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Cold start
    apply(32'h0, 0, 0, rnd_line());
    chk("t1_stall", 32'(iCacheStall), 32'd1);
    tick();
    apply(32'h0, 0, 1, line0);
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", mem_addr, 32'h0);
    tick();
    apply(32'h0, 0, 0, rnd_line());
    chk("t1_instr", instr, 32'h11);
    chk("t1_stall0", 32'(iCacheStall), 32'd0);
    chk("t1_cnt", miss_count, 32'd1);
    tick();

    // Same-line hits
    for (int i = 1; i < 4; i++) begin
      apply(32'(i * 4), 0, 0, rnd_line());
      chk("t2_instr", instr, 32'(8'h11 * (i + 1)));
      chk("t2_stall", 32'(iCacheStall), 32'd0);
      chk("t2_req", 32'(mem_req), 32'd0);
      tick();
    end

    // Slow memory: three wait cycles
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      apply(32'h40, 0, (k == 4), rnd_line());
      if (iCacheStall) begin
        stalls++;
        chk("t3_nop", instr, NOP);
      end
      if (k >= 1 && k <= 4) chk("t3_addr", mem_addr, 32'h40);
      tick();
    end
    chk("t3_stalls", 32'(stalls), 32'd5);

    // Conflict: 0x0 was evicted by 0x40
    miss_fill(32'h0, 0);
    apply(32'h0, 0, 0, rnd_line());
    chk("t4_cnt3", miss_count, 32'd3);
    tick();
    miss_fill(32'h40, 1);
    apply(32'h44, 0, 0, rnd_line());
    chk("t4_cnt4", miss_count, 32'd4);
    tick();

    // Redirect during fill
    apply(32'h100, 0, 0, rnd_line()); tick();
    apply(32'h200, 0, 0, rnd_line());
    chk("t5_addr_old", mem_addr, 32'h100);
    tick();
    apply(32'h200, 0, 1, rnd_line()); tick();
    apply(32'h200, 0, 0, rnd_line());
    chk("t5_remiss", 32'(iCacheStall), 32'd1);
    tick();
    apply(32'h200, 0, 1, rnd_line());
    chk("t5_addr_new", mem_addr, 32'h200);
    tick();
    // Invalidate in IDLE while hitting
    apply(32'h204, 1, 0, rnd_line());
    chk("t5_hit", 32'(iCacheStall), 32'd0);
    tick();
    apply(32'h204, 0, 0, rnd_line());
    chk("t5_inv_stall", 32'(iCacheStall), 32'd1);
    tick();
    // Invalidate on the fill-completion edge
    apply(32'h204, 1, 1, rnd_line()); tick();
    apply(32'h204, 0, 0, rnd_line());
    chk("t5_inv_fill", 32'(iCacheStall), 32'd0);
    tick();

    // Reset mid-fill
    apply(32'h300, 0, 0, rnd_line()); tick();
    apply(32'h300, 0, 0, rnd_line());
    reset = 1'b1;
    #1;
    chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_stall", 32'(iCacheStall), 32'd1);
    chk("t6_instr", instr, NOP);
    chk("t6_cnt", miss_count, 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    apply(32'h0, 0, 1, rnd_line());
    chk("t6_ignored", 32'(mem_req), 32'd0);
    tick();
    apply(32'h0, 0, 0, rnd_line());
    chk("t6_remiss_req", 32'(mem_req), 32'd1);
    tick();
    apply(32'h0, 0, 1, rnd_line()); tick();

    // Randomized traffic over eight lines with redirects, invalidates and stray responses
    rp = 32'h0;
    for (int n = 0; n < 600; n++) begin
      hold = m_pend && ($urandom_range(0, 3) != 0);
      if (!hold) rp = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      apply(rp, ($urandom_range(0, 29) == 0),
            m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0),
            rnd_line());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
